// File: rtl/dram_request_scheduler_if.sv
// Bundles the camera write stream, display read stream and DDR3 request port
// seen by the request scheduler; master is the scheduler side.
interface dram_request_scheduler_if #(
  parameter int ADDR_W = 24
);
  logic [127:0]      write_axis_data;
  logic              write_axis_tlast;
  logic              write_axis_valid;
  logic              write_axis_ready;
  logic [127:0]      read_axis_data;
  logic              read_axis_tlast;
  logic              read_axis_valid;
  logic              read_axis_ready;
  logic              read_axis_af;
  logic [ADDR_W-1:0] memrequest_addr;
  logic              memrequest_en;
  logic              memrequest_write_enable;
  logic [127:0]      memrequest_write_data;
  logic              memrequest_busy;
  logic              memrequest_complete;
  logic [127:0]      memrequest_resp_data;
  logic [1:0]        status_err;

  modport master (
    input  write_axis_data, write_axis_tlast, write_axis_valid,
    output write_axis_ready,
    output read_axis_data, read_axis_tlast, read_axis_valid,
    input  read_axis_ready, read_axis_af,
    output memrequest_addr, memrequest_en, memrequest_write_enable, memrequest_write_data,
    input  memrequest_busy, memrequest_complete, memrequest_resp_data,
    output status_err
  );

  modport slave (
    output write_axis_data, write_axis_tlast, write_axis_valid,
    input  write_axis_ready,
    input  read_axis_data, read_axis_tlast, read_axis_valid,
    output read_axis_ready, read_axis_af,
    input  memrequest_addr, memrequest_en, memrequest_write_enable, memrequest_write_data,
    output memrequest_busy, memrequest_complete, memrequest_resp_data,
    input  status_err
  );
endinterface

// File: rtl/dram_request_scheduler.sv
// Arbitrates the single DDR3 request port between camera writes and display
// prefetch reads, with bounded write runs and bounded outstanding requests.
module dram_request_scheduler #(
  parameter int MAX_ADDR  = 115200,
  parameter int ADDR_W    = 24,
  parameter int MAX_OUT   = 8,
  parameter int WRITE_RUN = 16
) (
  input logic clk,
  input logic rst,
  dram_request_scheduler_if.master bus
);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam int RUN_W = $clog2(WRITE_RUN + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR - 1);
  localparam logic [CNT_W-1:0]  OUT_LIMIT = CNT_W'(MAX_OUT);
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(WRITE_RUN);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         tag_q [MAX_OUT];
  logic [1:0]         tag_d [MAX_OUT];
  logic               is_last_q, is_last_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [127:0]       mem_wdata_q, mem_wdata_d;
  logic               rvalid_q, rvalid_d;
  logic               rlast_q, rlast_d;
  logic [127:0]       rdata_q, rdata_d;
  logic [1:0]         err_q, err_d;

  logic has_room, w_elig, r_elig, grant_w, grant_r, accept, pop;
  logic [1:0] head_tag;

  // Arbitration, request issue, tag queue and response routing.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    run_d       = run_q;
    out_cnt_d   = out_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_d       = tag_q;
    is_last_d   = is_last_q;
    mem_addr_d  = mem_addr_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;

    has_room = (out_cnt_q < OUT_LIMIT);
    w_elig   = (state_q == IDLE) && bus.write_axis_valid && has_room;
    r_elig   = (state_q == IDLE) && !bus.read_axis_af && has_room;
    grant_w  = w_elig && (!r_elig || (run_q < RUN_LIMIT));
    grant_r  = r_elig && !grant_w;
    accept   = (state_q == ISSUE) && mem_en_q && !bus.memrequest_busy;
    pop      = bus.memrequest_complete && (out_cnt_q != CNT_W'(0));
    head_tag = tag_q[rd_ptr_q];

    case (state_q)
      IDLE: begin
        if (grant_w) begin
          mem_addr_d  = wr_addr_q;
          mem_we_d    = 1'b1;
          mem_wdata_d = bus.write_axis_data;
          mem_en_d    = 1'b1;
          is_last_d   = 1'b0;
          wr_addr_d   = (bus.write_axis_tlast || (wr_addr_q == LAST_ADDR)) ?
                        ADDR_W'(0) : wr_addr_q + ADDR_W'(1);
          state_d     = ISSUE;
        end else if (grant_r) begin
          mem_addr_d  = rd_addr_q;
          mem_we_d    = 1'b0;
          mem_en_d    = 1'b1;
          is_last_d   = (rd_addr_q == LAST_ADDR);
          rd_addr_d   = (rd_addr_q == LAST_ADDR) ? ADDR_W'(0) : rd_addr_q + ADDR_W'(1);
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (accept) begin
          tag_d[wr_ptr_q] = {mem_we_q, is_last_q};
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
          mem_en_d        = 1'b0;
          state_d         = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        mem_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (grant_w) begin
      run_d = (run_q < RUN_LIMIT) ? run_q + RUN_W'(1) : run_q;
    end else if (grant_r || ((state_q == IDLE) && !w_elig)) begin
      run_d = RUN_W'(0);
    end else begin
      run_d = run_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept, pop})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Acks return in issue order, so the queue head always names the acked request.
    rvalid_d = pop && !head_tag[1];
    rlast_d  = rvalid_d ? head_tag[0] : 1'b0;
    rdata_d  = rvalid_d ? bus.memrequest_resp_data : rdata_q;
    err_d[0] = err_q[0] | (rvalid_q & ~bus.read_axis_ready);
    err_d[1] = err_q[1] | (bus.memrequest_complete & (out_cnt_q == CNT_W'(0)));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= ADDR_W'(0);
      rd_addr_q   <= ADDR_W'(0);
      run_q       <= RUN_W'(0);
      out_cnt_q   <= CNT_W'(0);
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      for (int i = 0; i < MAX_OUT; i++) tag_q[i] <= 2'b00;
      is_last_q   <= 1'b0;
      mem_addr_q  <= ADDR_W'(0);
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 128'd0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= 128'd0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      run_q       <= run_d;
      out_cnt_q   <= out_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_q       <= tag_d;
      is_last_q   <= is_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.write_axis_ready        = grant_w;
  assign bus.read_axis_data          = rdata_q;
  assign bus.read_axis_tlast         = rlast_q;
  assign bus.read_axis_valid         = rvalid_q;
  assign bus.memrequest_addr         = mem_addr_q;
  assign bus.memrequest_en           = mem_en_q;
  assign bus.memrequest_write_enable = mem_we_q;
  assign bus.memrequest_write_data   = mem_wdata_q;
  assign bus.status_err              = err_q;
endmodule

// File: doc/dram_request_scheduler.md
# dram_request_scheduler

Schedules the single request port of the DDR3 memory controller between the camera write stream and the display read stream of the HD frame buffer, on the 83.333 MHz controller clock. Consumes 128-bit write beats from the camera-side clock-domain FIFO and issues prefetch reads for the display-side FIFO. Walks both linear frame addresses with wrap and tlast resynchronisation, and tags outstanding requests so in-order acks are routed back correctly. Replaces ad-hoc read/write sequencing with a bounded-fairness, bounded-outstanding scheduler.

## Interface
- MAX_ADDR, 115200, number of 128-bit words per frame (1280*720/8); addresses run 0..MAX_ADDR-1
- ADDR_W, 24, width of memrequest_addr
- MAX_OUT, 8, maximum requests accepted by controller but not yet acked (power of two, 2..32)
- WRITE_RUN, 16, maximum consecutive write grants while a read is eligible

Ports:
- clk  in  1  controller clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- write_axis_data  in  128  camera beat
- write_axis_tlast  in  1  last beat of frame
- write_axis_valid  in  1  beat available
- write_axis_ready  out  1  beat consumed this cycle
- read_axis_data  out  128  read response to display FIFO
- read_axis_tlast  out  1  response belongs to address MAX_ADDR-1
- read_axis_valid  out  1  response valid (one-cycle pulse per read)
- read_axis_ready  in  1  display FIFO can accept
- read_axis_af  in  1  display FIFO almost full; blocks new reads
- memrequest_addr  out  ADDR_W  request address
- memrequest_en  out  1  request strobe
- memrequest_write_enable  out  1  1 = write, 0 = read
- memrequest_write_data  out  128  write payload
- memrequest_busy  in  1  controller stall
- memrequest_complete  in  1  ack, one per accepted request, in issue order
- memrequest_resp_data  in  128  read data, valid with ack of a read
- status_err  out  2  sticky: [0] read response dropped, [1] ack with no outstanding tag

## Operation
- States IDLE, ISSUE. Reset → IDLE; all outputs 0; wr_addr = rd_addr = 0; tag queue empty; run counter 0.
- Eligibility in IDLE: W = write_axis_valid && outstanding < MAX_OUT; R = !read_axis_af && outstanding < MAX_OUT.
- Grant: W only → write; R only → read; both → write if run < WRITE_RUN, else read. Neither → stay IDLE.
- Run counter: +1 on write grant (saturating at WRITE_RUN), cleared on read grant and whenever IDLE with W = 0.
- Write grant: write_axis_ready = 1 same cycle (combinational on state/eligibility); latch data, addr = wr_addr, we = 1; next wr_addr = 0 if tlast or wr_addr == MAX_ADDR-1, else wr_addr+1. → ISSUE.
- Read grant: latch addr = rd_addr, we = 0, tag is_last = (rd_addr == MAX_ADDR-1); rd_addr wraps MAX_ADDR-1 → 0. → ISSUE.
- ISSUE: memrequest_en = 1, addr/data/we held stable; accept = en && !busy; on accept push tag {is_write, is_last}, deassert en next cycle, → IDLE.
- Ack: pop tag. Read tag → next cycle read_axis_valid = 1, data = resp_data, tlast = is_last. If read_axis_ready = 0 that cycle, beat is lost and status_err[0] sets. Write tag → no output.
- Ack with empty queue → ignored, status_err[1] sets.
- Accept and ack in same cycle → outstanding unchanged; pop applies to oldest tag (the queue is never empty-then-pushed for the same entry).
- Reset mid-operation discards held request and tags; rst is shared with the controller, so late acks are not expected.

## Timing
- Grant to memrequest_en: 1 cycle. Minimum issue spacing: 2 cycles (IDLE + ISSUE with busy = 0).
- Ack to read_axis_valid: 1 cycle, registered.
- read_axis_af sampled only in IDLE; a read already in ISSUE completes regardless.
- status_err clears only on rst.

## Test plan
- Writes only, busy = 0, 4 beats, tlast on 2nd: addrs 0,1,0,1; write_axis_ready one cycle per beat; en every other cycle.
- Reads only, af = 0, MAX_ADDR = 4, 6 reads acked: addrs 0,1,2,3,0,1; read_axis_tlast on 4th response only.
- Both eligible continuously, WRITE_RUN = 2: grant order W,W,R,W,W,R; run resets after R.
- Hold acks, MAX_OUT = 4: exactly 4 accepts then no grant; one ack → one further grant.
- busy = 1 for 5 cycles in ISSUE: addr/data/we constant, en held, single tag pushed after busy drops.
- Ack with no outstanding → status_err = 2'b10; read ack with read_axis_ready = 0 → status_err[0] = 1; rst → 0.
